pushbutton_rgb_ctrl: RTL and testbench
======================================

# pushbutton_rgb_ctrl

Reads the board's active-low push-button, synchronises and debounces it, and emits clean press, release and long-press events. A small colour state machine uses those events to select the colour shown on the active-low RGB LED. This block is the input-side counterpart of the fixed LED drivers: the same `redled`/`greenled`/`blueled` pins, now under user control.

## Interface
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles needed to accept a level change (20 ms at 12 MHz). Legal values are 2 or more.
- `LONG_CYCLES`, default 12000000: held-pressed cycles before a long press fires (1 s at 12 MHz). Must be greater than `DEBOUNCE_CYCLES`.

- `clk`  in  1  single system clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_n`  in  1  raw push-button, asynchronous to `clk`; 0 = pressed.
- `btn_state`  out  1  debounced level; 1 = pressed.
- `press`  out  1  one-cycle pulse when a press is accepted.
- `release`  out  1  one-cycle pulse when a release is accepted.
- `long_press`  out  1  one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `redled`  out  1  active-low LED drive; 0 = lit.
- `greenled`  out  1  active-low LED drive; 0 = lit.
- `blueled`  out  1  active-low LED drive; 0 = lit.

## Operation
- **Synchroniser.** Two flops carry `btn_n` into the clock domain. Both flops reset to 1 (released). `sync` is the inverted second-stage output, so 1 = pressed.
- **Debounce.**
  - The counter increments on every edge where `sync != btn_state`.
  - It clears to 0 on any edge where they are equal.
  - On the edge where the counter equals `DEBOUNCE_CYCLES-1` and `sync != btn_state`, three things happen together: `btn_state <= sync`, the counter clears, and `press` or `release` is set for one cycle.
  - Any glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event.
- **Hold counter.**
  - Clears on the press edge, then increments each cycle while `btn_state == 1`, saturating.
  - On the edge where it equals `LONG_CYCLES-1`, `long_press` pulses once and the `fired` flag sets.
  - `fired` clears on the release edge.
- **Colour FSM.** States are OFF, RED, GREEN, BLUE, WHITE.
  - A release with `fired == 0` advances the state: OFF -> RED -> GREEN -> BLUE -> WHITE -> OFF.
  - A release with `fired == 1` leaves the state unchanged.
  - `long_press` forces OFF from any state, on the same edge that `long_press` is set.
  - `press` alone never changes the state.
- **LED decode.** LEDs are registered from the state, and the FSM and LED registers update on the same edge.
  - OFF: all three LEDs = 1.
  - RED: `redled` = 0.
  - GREEN: `greenled` = 0.
  - BLUE: `blueled` = 0.
  - WHITE: all three LEDs = 0.
- **Reset values.**
  - Outputs: `btn_state`, `press`, `release`, `long_press` = 0; `redled`, `greenled`, `blueled` = 1.
  - Internal state: FSM in OFF, both counters 0, `fired` = 0.
- **Reset mid-operation.** Asserting `rst_n` clears all state immediately, including a partial debounce or hold count. After deassertion with the button held, a fresh press is accepted after the full debounce latency.

## Timing
- **Press latency.** `btn_n` falls and is sampled at edge k and stays low. `sync` = 1 from edge k+1. `btn_state` and `press` go high after edge k+1+`DEBOUNCE_CYCLES`.
- **Release latency.** Symmetric with press latency. The LED change is visible on the same edge as the `release` pulse.
- **Long-press latency.** `long_press` goes high `LONG_CYCLES` edges after the `press` edge.
- **Pulse rules.** `press`, `release` and `long_press` are each exactly one cycle wide. `press` and `release` can never assert in the same cycle.
- **Counter widths.** Each counter is `$clog2` of its limit plus 1 bit. The hold counter saturates and never wraps, so a hold of any length fires `long_press` only once.

## Test plan
Use `DEBOUNCE_CYCLES` = 4 and `LONG_CYCLES` = 20 throughout.
- **Reset.** Hold `rst_n` = 0 for 3 cycles, then release it with `btn_n` = 1 -> all LEDs = 1, pulses = 0, `btn_state` = 0 for 50 cycles.
- **Glitch rejection.** `btn_n` low for 3 cycles, then high -> no `press`, `btn_state` stays 0, LEDs unchanged.
- **Clean press.** `btn_n` low at edge k, held 10 cycles, then high -> `press` high only in the cycle after edge k+5. `release` pulses 5 edges after the rise. `redled` = 0, `greenled` = `blueled` = 1.
- **Cycle through colours.** Five clean 10-cycle presses from OFF -> RED, GREEN, BLUE, WHITE (all LEDs 0), then OFF (all LEDs 1). One `release` per step.
- **Long press.** From GREEN, hold `btn_n` low for 40 cycles -> `long_press` pulses once, 20 cycles after `press`, and the LEDs go all 1 on that edge. The subsequent release leaves the state at OFF.
- **Reset mid-operation.** Assert `rst_n` two cycles into a debounce, with `btn_n` still low -> outputs are at reset values immediately. After deassertion, `press` arrives 5 edges later.

Source files
------------

// File: rtl/pushbutton_rgb_ctrl.sv
// pushbutton_rgb_ctrl: debounced push-button events driving a five-colour active-low RGB LED state machine
module pushbutton_rgb_ctrl #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic btn_state_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic redled_o,
  output logic greenled_o,
  output logic blueled_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_RED   = 3'd1;
  localparam logic [2:0] S_GREEN = 3'd2;
  localparam logic [2:0] S_BLUE  = 3'd3;
  localparam logic [2:0] S_WHITE = 3'd4;

  logic          sync1_q, sync2_q, sync, diff, db_done;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          btn_q, btn_d, press_q, press_d, rel_q, rel_d, long_q, long_d, fired_q, fired_d;
  logic [2:0]    st_q, st_d, led_q, led_d;

  always_comb begin
    sync     = ~sync2_q;
    diff     = sync != btn_q;
    db_done  = diff && db_cnt_q == DB_LAST;
    db_cnt_d = (diff && !db_done) ? db_cnt_q + DW'(1) : '0;
    btn_d    = db_done ? sync : btn_q;
    press_d  = db_done && sync;
    rel_d    = db_done && !sync;
    long_d   = btn_q && hold_q == HOLD_LAST;
    // saturate one past the firing value so a long hold fires exactly once
    hold_d   = press_d ? '0 : (btn_q && hold_q != HOLD_MAX) ? hold_q + HW'(1) : hold_q;
    fired_d  = rel_d ? 1'b0 : long_d ? 1'b1 : fired_q;
    st_d     = long_d ? S_OFF :
               (rel_d && !fired_q) ? ((st_q == S_WHITE) ? S_OFF : st_q + 3'd1) : st_q;
    led_d    = (st_d == S_OFF)   ? 3'b111 :
               (st_d == S_RED)   ? 3'b011 :
               (st_d == S_GREEN) ? 3'b101 :
               (st_d == S_BLUE)  ? 3'b110 : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_cnt_q <= '0;
      hold_q   <= '0;
      btn_q    <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
      fired_q  <= 1'b0;
      st_q     <= S_OFF;
      led_q    <= 3'b111;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
      btn_q    <= btn_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
      fired_q  <= fired_d;
      st_q     <= st_d;
      led_q    <= led_d;
    end
  end

  assign btn_state_o  = btn_q;
  assign press_o      = press_q;
  assign release_o    = rel_q;
  assign long_press_o = long_q;
  assign {redled_o, greenled_o, blueled_o} = led_q;
endmodule

// File: tb/tb_pushbutton_rgb_ctrl.sv
// tb_pushbutton_rgb_ctrl: scoreboard bench checking event timing and LED colours of pushbutton_rgb_ctrl
module tb_pushbutton_rgb_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, btn_n = 1'b1;
  logic btn_state, press, rel, long_press, redled, greenled, blueled;
  int tests = 0, fails = 0, cyc = 0, col = 0;

  typedef struct {int cyc; logic [2:0] ev; logic [2:0] led;} exp_t;
  exp_t q[$];

  pushbutton_rgb_ctrl #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n_i(btn_n), .btn_state_o(btn_state),
    .press_o(press), .release_o(rel), .long_press_o(long_press),
    .redled_o(redled), .greenled_o(greenled), .blueled_o(blueled)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] leds_of(input int c);
    case (c)
      0: return 3'b111;
      1: return 3'b011;
      2: return 3'b101;
      3: return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic tick();
    logic [2:0] ev, led;
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    ev  = {press, rel, long_press};
    led = {redled, greenled, blueled};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL missed_event at cyc %0d: saw none, wanted ev=%b at cyc %0d", cyc, q[0].ev, q[0].cyc);
      void'(q.pop_front());
    end
    if (ev !== 3'b000) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event at cyc %0d: got ev=%b, wanted none", cyc, ev);
      end else begin
        e = q.pop_front();
        if (e.cyc !== cyc || e.ev !== ev || e.led !== led) begin
          fails++;
          $display("FAIL event at cyc %0d: got ev=%b led=%b, wanted ev=%b led=%b at cyc %0d",
                   cyc, ev, led, e.ev, e.led, e.cyc);
        end
      end
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (q.size() != 0 || {redled, greenled, blueled} !== leds_of(col) || btn_state !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: pending=%0d led=%b btn=%b, wanted pending=0 led=%b btn=0",
               name, q.size(), {redled, greenled, blueled}, btn_state, leds_of(col));
    end
    q.delete();
  endtask

  task automatic check_reset_vals(input string name);
    tests++;
    if ({btn_state, press, rel, long_press} !== 4'b0000 || {redled, greenled, blueled} !== 3'b111) begin
      fails++;
      $display("FAIL %s: got btn/press/rel/long=%b led=%b, wanted 0000 and 111",
               name, {btn_state, press, rel, long_press}, {redled, greenled, blueled});
    end
  endtask

  task automatic tap(input int hold, input string name);
    int nc = (col + 1) % 5;
    btn_n = 1'b0;
    q.push_back('{cyc + 6, 3'b100, leds_of(col)});
    for (int i = 0; i < hold; i++) begin
      tick();
      if (i == 5) begin
        tests++;
        if (btn_state !== 1'b1) begin
          fails++;
          $display("FAIL %s btn_state: got %b, wanted 1", name, btn_state);
        end
      end
    end
    btn_n = 1'b1;
    q.push_back('{cyc + 6, 3'b010, leds_of(nc)});
    repeat (8) tick();
    col = nc;
    check_idle(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_n = 1'b1;
    q.delete();
    repeat (3) tick();
    check_reset_vals("reset_held");
    rst_n = 1'b1;
    col = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      tests++;
      if ({redled, greenled, blueled} !== 3'b111 || btn_state !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: led=%b btn=%b, wanted 111 and 0", cyc, {redled, greenled, blueled}, btn_state);
      end
    end
  endtask

  task automatic test_glitch();
    btn_n = 1'b0;
    repeat (3) tick();
    btn_n = 1'b1;
    repeat (10) tick();
    check_idle("glitch");
  endtask

  task automatic test_clean_press();
    tap(10, "clean_press");
  endtask

  task automatic test_cycle();
    test_reset();
    for (int i = 0; i < 5; i++) tap(10, "cycle");
  endtask

  task automatic test_long_press();
    tap(10, "to_red");
    tap(10, "to_green");
    btn_n = 1'b0;
    q.push_back('{cyc + 6, 3'b100, leds_of(col)});
    q.push_back('{cyc + 26, 3'b001, 3'b111});
    repeat (40) tick();
    col = 0;
    btn_n = 1'b1;
    q.push_back('{cyc + 6, 3'b010, 3'b111});
    repeat (8) tick();
    check_idle("long_press");
  endtask

  task automatic test_reset_mid();
    tap(10, "pre_reset");
    btn_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    col = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    q.push_back('{cyc + 6, 3'b100, 3'b111});
    repeat (10) tick();
    btn_n = 1'b1;
    q.push_back('{cyc + 6, 3'b010, 3'b011});
    repeat (8) tick();
    col = 1;
    check_idle("reset_mid_after");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_cycle();
    test_long_press();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
